truth_table_sweeper: RTL and testbench

Sequential stimulus-and-capture stage that wraps a bank of combinational 3-input logic functions (the f01-style x,y,z gate networks). On start it drives every input vector 000..111 in order, waits a settle time, samples all function outputs, and assembles one truth-table word per function. It then compares the result against an expected mask. It replaces hand-written #1 stimulus sequences with a clocked, self-checking sweep usable in both simulation and synthesis.

---
 rtl/truth_table_sweeper_if.sv | 44 ++++
 rtl/truth_table_sweeper.sv | 146 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_if
// Description : Bus bundle between a truth-table sweeper and its environment.
//               The slave modport is the sweeper itself: it receives the
//               sweep controls, the reference tables and the outputs of the
//               function bank, and drives the input vector, status and
//               captured tables. The master modport is the opposite side.
//   start/abort  : sweep control (master -> slave)
//   expected     : reference truth tables (master -> slave)
//   f_in         : function-bank outputs (master -> slave)
//   vec          : input vector for the function bank (slave -> master)
//   busy/done    : sweep status (slave -> master)
//   result_valid : truth_table/mismatch hold a complete sweep
//   truth_table  : truth_table[f*2**N_IN + v] = f_in[f] at vec=v
//   mismatch     : truth_table != expected
// Revision    : 1.0  initial release
// ============================================================================
interface truth_table_sweeper_if #(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 5
);
  logic                         start;
  logic                         abort;
  logic [N_FUNC*(2**N_IN)-1:0]  expected;
  logic [N_FUNC-1:0]            f_in;
  logic [N_IN-1:0]              vec;
  logic                         busy;
  logic                         done;
  logic                         result_valid;
  logic [N_FUNC*(2**N_IN)-1:0]  truth_table;
  logic                         mismatch;

  modport master (
    output start, abort, expected, f_in,
    input  vec, busy, done, result_valid, truth_table, mismatch
  );

  modport slave (
    input  start, abort, expected, f_in,
    output vec, busy, done, result_valid, truth_table, mismatch
  );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Clocked stimulus-and-capture stage for a bank of N_FUNC
//               combinational N_IN-input functions. On start it walks vec
//               through 0 .. 2**N_IN-1, holding each vector SETTLE cycles,
//               samples every function output at the end of the hold, packs
//               one truth-table word per function and compares the packed
//               result against a reference.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - truth_table_sweeper_if.slave
//                       (start, abort, expected, f_in in;
//                        vec, busy, done, result_valid, truth_table,
//                        mismatch out)
// Parameters  : N_IN   - function inputs, 2**N_IN vectors per sweep
//               N_FUNC - function outputs captured
//               SETTLE - cycles per vector before sampling, 1..15
// Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 5,
  parameter int SETTLE = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  truth_table_sweeper_if.slave   bus
);

  localparam int C_NVEC = 2**N_IN;
  localparam int C_TW   = N_FUNC * C_NVEC;

  // Last vector of a sweep; the DONE transition happens here so vec never wraps.
  localparam logic [N_IN-1:0] C_VEC_LAST    = '1;
  localparam logic [3:0]      C_SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_vec;
  logic [3:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_result_valid;
  logic              r_mismatch;
  logic [C_TW-1:0]   r_table;

  logic              w_settled;
  logic [C_TW-1:0]   w_captured;

  assign w_settled = (r_cnt == C_SETTLE_LAST);

  // Table as it will look once the current vector is captured. Each function
  // owns an aligned 2**N_IN-bit slice, so the bit to replace is selected by
  // vec alone and the index width matches the slice exactly.
  generate
    for (genvar f = 0; f < N_FUNC; f++) begin : g_capture
      logic [C_NVEC-1:0] w_slice;

      always_comb begin
        w_slice        = r_table[f*C_NVEC +: C_NVEC];
        w_slice[r_vec] = bus.f_in[f];
      end

      assign w_captured[f*C_NVEC +: C_NVEC] = w_slice;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_vec          <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_mismatch     <= 1'b0;
      r_table        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // start beats abort here: abort only acts on a running sweep.
          if (bus.start) begin
            r_state        <= S_WAIT;
            r_vec          <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b1;
            r_table        <= '0;
            r_result_valid <= 1'b0;
            r_mismatch     <= 1'b0;
          end
        end

        S_WAIT: begin
          if (bus.abort) begin
            // Partial table is left as-is; result_valid is already low.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_vec   <= '0;
            r_cnt   <= '0;
          end else if (w_settled) begin
            r_table <= w_captured;
            r_cnt   <= '0;
            if (r_vec == C_VEC_LAST) begin
              r_state        <= S_DONE;
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_result_valid <= 1'b1;
              // Compare the table including the vector captured on this edge.
              r_mismatch     <= (w_captured != bus.expected);
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec          = r_vec;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_result_valid;
  assign bus.truth_table  = r_table;
  assign bus.mismatch     = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed bench for truth_table_sweeper. Two instances share
//               clock and reset: u_dut1 with SETTLE=1 and u_dut3 with
//               SETTLE=3. Each f_in is driven by the five-function x,y,z
//               gate bank evaluated on that instance's vec.
// Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;

  localparam logic [39:0] C_TT     = 40'h44_A2_45_80_04;
  localparam logic [39:0] C_TT_BAD = 40'h44_A2_45_80_00;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3), .N_FUNC(5)) b1 ();
  truth_table_sweeper_if #(.N_IN(3), .N_FUNC(5)) b3 ();

  truth_table_sweeper #(.N_IN(3), .N_FUNC(5), .SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  truth_table_sweeper #(.N_IN(3), .N_FUNC(5), .SETTLE(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  // Function bank, returned as {e,d,c,b,a}.
  function automatic logic [4:0] bank(input logic [2:0] v);
    logic x, y, z, a, b, c, d, e;
    x = v[2];
    y = v[1];
    z = v[0];
    a = ~x & ~(~y | z);
    b = ~(~x | ~y) & z;
    c = ~(x & ~y) & ~z;
    d = ~(~x & y) & z;
    e = (~x | y) & ~(~y | z);
    return {e, d, c, b, a};
  endfunction

  assign b1.f_in = bank(b1.vec);
  assign b3.f_in = bank(b3.vec);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen; a stalled sweep returns 100.
  task automatic wait_done(input bit sel3, output int n);
    n = 0;
    while (n < 100 && !(sel3 ? b3.done : b1.done)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int seen;

    rst_n       = 1'b0;
    b1.start    = 1'b0;
    b1.abort    = 1'b0;
    b1.expected = C_TT;
    b3.start    = 1'b0;
    b3.abort    = 1'b0;
    b3.expected = C_TT;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_vec",    64'(b1.vec),          64'd0);
    check("rst_busy",   64'(b1.busy),         64'd0);
    check("rst_done",   64'(b1.done),         64'd0);
    check("rst_rv",     64'(b1.result_valid), 64'd0);
    check("rst_table",  64'(b1.truth_table),  64'd0);
    check("rst_mm",     64'(b1.mismatch),     64'd0);

    // Reset in the middle of a sweep
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("mid_busy", 64'(b1.busy), 64'd1);
    tick();
    tick();
    tick();
    check("mid_vec3", 64'(b1.vec), 64'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_vec",   64'(b1.vec),          64'd0);
    check("midrst_busy",  64'(b1.busy),         64'd0);
    check("midrst_table", 64'(b1.truth_table),  64'd0);
    check("midrst_rv",    64'(b1.result_valid), 64'd0);

    // Full sweep, SETTLE=1
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("s1_vec0", 64'(b1.vec), 64'd0);
    wait_done(1'b0, n);
    check("s1_latency", 64'(n),               64'd8);
    check("s1_table",   64'(b1.truth_table),  64'(C_TT));
    check("s1_rv",      64'(b1.result_valid), 64'd1);
    check("s1_mm",      64'(b1.mismatch),     64'd0);
    check("s1_busy",    64'(b1.busy),         64'd0);
    check("s1_vec7",    64'(b1.vec),          64'd7);
    tick();
    check("s1_done_pulse", 64'(b1.done),         64'd0);
    check("s1_rv_hold",    64'(b1.result_valid), 64'd1);
    check("s1_tbl_hold",   64'(b1.truth_table),  64'(C_TT));
    check("s1_vec_hold",   64'(b1.vec),          64'd7);

    // Full sweep, SETTLE=3: each vector held three cycles
    b3.start = 1'b1;
    tick();
    b3.start = 1'b0;
    n = 0;
    while (n < 100 && !b3.done) begin
      check($sformatf("s3_vec_c%0d", n), 64'(b3.vec), 64'(n / 3));
      tick();
      n++;
    end
    check("s3_latency", 64'(n),               64'd24);
    check("s3_table",   64'(b3.truth_table),  64'(C_TT));
    check("s3_rv",      64'(b3.result_valid), 64'd1);
    check("s3_mm",      64'(b3.mismatch),     64'd0);

    // Mismatch: function a, vector 010 cleared in the reference
    b1.expected = C_TT_BAD;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    wait_done(1'b0, n);
    check("mm_latency", 64'(n),               64'd8);
    check("mm_flag",    64'(b1.mismatch),     64'd1);
    check("mm_rv",      64'(b1.result_valid), 64'd1);
    check("mm_table",   64'(b1.truth_table),  64'(C_TT));
    tick();
    tick();
    check("mm_hold", 64'(b1.mismatch), 64'd1);

    // Abort while idle changes nothing
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    check("idle_abort_busy", 64'(b1.busy),         64'd0);
    check("idle_abort_rv",   64'(b1.result_valid), 64'd1);
    check("idle_abort_mm",   64'(b1.mismatch),     64'd1);
    b1.expected = C_TT;

    // Start during a sweep is ignored; abort at vec=5
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("ab_rv_clear", 64'(b1.result_valid), 64'd0);
    tick();
    tick();
    check("ab_vec2", 64'(b1.vec), 64'd2);
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("ab_norestart_vec", 64'(b1.vec),  64'd3);
    check("ab_norestart_bsy", 64'(b1.busy), 64'd1);
    tick();
    tick();
    check("ab_vec5", 64'(b1.vec), 64'd5);
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    check("ab_busy", 64'(b1.busy),         64'd0);
    check("ab_vec",  64'(b1.vec),          64'd0);
    check("ab_rv",   64'(b1.result_valid), 64'd0);
    check("ab_done", 64'(b1.done),         64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (b1.done) seen++;
      tick();
    end
    check("ab_no_done", 64'(seen),    64'd0);
    check("ab_idle",    64'(b1.busy), 64'd0);

    // Back-to-back: start (with abort also high) on the cycle after done
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    wait_done(1'b0, n);
    check("bb_first_latency", 64'(n), 64'd8);
    tick();
    check("bb_done_low", 64'(b1.done), 64'd0);
    b1.start = 1'b1;
    b1.abort = 1'b1;
    tick();
    b1.start = 1'b0;
    b1.abort = 1'b0;
    check("bb_busy",  64'(b1.busy),         64'd1);
    check("bb_vec",   64'(b1.vec),          64'd0);
    check("bb_table", 64'(b1.truth_table),  64'd0);
    check("bb_rv",    64'(b1.result_valid), 64'd0);
    wait_done(1'b0, n);
    check("bb_latency", 64'(n),              64'd8);
    check("bb_table2",  64'(b1.truth_table), 64'(C_TT));
    check("bb_mm",      64'(b1.mismatch),    64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
